mem_slot_arbiter: RTL

- Shares one single-port synchronous memory between NUM_REQ requesters using a fixed 4-cycle access frame.
- Frame phases: 0 = arbitrate/latch, 1 = address setup, 2 = write slot, 3 = read slot.
- Sits between the placement engines (requesters) and the shared placement-state RAM.
- Grants one access per frame, round-robin, and returns a tagged response for each granted access.

---
 rtl/mem_slot_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_slot_arbiter
// Function : Round-robin sharing of one single-port synchronous RAM between
//            NUM_REQ requesters using a fixed 4-cycle access frame.
// Revision : 1.0 - initial release
// ============================================================================
module mem_slot_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_is_write,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                phase,
    output logic                      busy
);

    typedef enum logic [1:0] {
        PH_ARB   = 2'd0,
        PH_SETUP = 2'd1,
        PH_WRITE = 2'd2,
        PH_READ  = 2'd3
    } phase_t;

    phase_t              r_phase;
    phase_t              w_phase_next;

    logic [ID_W-1:0]     r_rr_ptr;
    logic                r_busy;
    logic                r_op_wr;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                r_pend;
    logic                r_pend_wr;
    logic [ID_W-1:0]     r_pend_id;

    logic                r_rsp_valid;
    logic                r_rsp_wr;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic                w_grant_vld;
    logic [ID_W-1:0]     w_grant_idx;
    logic [ID_W-1:0]     w_rr_next;
    logic [NUM_REQ-1:0]  w_ready;

    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    // Frame sequencer: free-running, one access slot per 4 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_ARB;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_phase_next = PH_ARB;
        case (r_phase)
            PH_ARB:   w_phase_next = PH_SETUP;
            PH_SETUP: w_phase_next = PH_WRITE;
            PH_WRITE: w_phase_next = PH_READ;
            PH_READ:  w_phase_next = PH_ARB;
            default:  w_phase_next = PH_ARB;
        endcase
    end

    // First valid requester at or above the round-robin pointer, wrapping.
    always_comb begin
        int              j;
        logic [ID_W-1:0] cand;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        j           = 0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cand = ID_W'(j);
            if (!w_grant_vld && req_valid[cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = cand;
            end
        end
    end

    always_comb begin
        if (w_grant_idx == ID_W'(NUM_REQ - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_grant_idx + ID_W'(1);
        end
    end

    // Gated by rst so no handshake can complete while the block is held in reset.
    always_comb begin
        w_ready = '0;
        if (!rst && (r_phase == PH_ARB) && w_grant_vld) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_busy      <= 1'b0;
            r_op_wr     <= 1'b0;
            r_id        <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pend      <= 1'b0;
            r_pend_wr   <= 1'b0;
            r_pend_id   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_phase)
                PH_ARB: begin
                    if (w_grant_vld) begin
                        r_busy      <= 1'b1;
                        r_op_wr     <= req_write[w_grant_idx];
                        r_id        <= w_grant_idx;
                        r_mem_addr  <= w_addr_arr[w_grant_idx];
                        r_mem_wdata <= w_wdata_arr[w_grant_idx];
                        r_rr_ptr    <= w_rr_next;
                    end else begin
                        r_busy      <= 1'b0;
                    end
                    // Previous frame's read data is on mem_rdata during this phase.
                    r_rsp_valid <= r_pend;
                    r_rsp_id    <= r_pend_id;
                    r_rsp_wr    <= r_pend_wr;
                    r_rsp_rdata <= r_pend_wr ? '0 : mem_rdata;
                end
                PH_SETUP: begin
                    r_rsp_valid <= 1'b0;
                end
                PH_READ: begin
                    r_pend    <= r_busy;
                    r_pend_id <= r_id;
                    r_pend_wr <= r_op_wr;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready    = w_ready;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_we       = (r_phase == PH_WRITE) & r_busy & r_op_wr;
    assign mem_re       = (r_phase == PH_READ)  & r_busy & ~r_op_wr;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_is_write = r_rsp_wr;
    assign rsp_rdata    = r_rsp_rdata;
    assign phase        = r_phase;
    assign busy         = r_busy;

endmodule
`default_nettype wire
